mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller that serialises instruction fetches (IF) and data accesses (MEM) onto the single 8-bit RAM port. It arbitrates between the two stages and assembles or splits little-endian words byte by byte. It generates the `if_stall` and `mem_stall` requests consumed by the pipeline stall controller, so it sits between the IF/MEM stages and the RAM/IO bus.

## Interface
- No parameters; all widths and encodings come from `consts.vh`.
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `rdy`  in  1  global ready; low freezes the block
- `if_req`  in  1  fetch request; held until `if_done`
- `if_addr`  in  32  fetch address; word access
- `if_done`  out  1  one-cycle pulse; `if_data` valid
- `if_data`  out  32  fetched instruction
- `mem_req`  in  1  data request; held until `mem_done`
- `mem_we`  in  1  1 = store, 0 = load
- `mem_size`  in  2  `SIZE_B`=0 (1 byte), `SIZE_H`=1 (2 bytes), `SIZE_W`=2 (4 bytes)
- `mem_addr`  in  32  byte address
- `mem_wdata`  in  32  store data, low bytes used
- `mem_done`  out  1  one-cycle pulse; `mem_rdata` valid on loads
- `mem_rdata`  out  32  load data, zero-extended; the MEM stage sign-extends
- `if_stall`  out  1  `if_req & ~if_done`
- `mem_stall`  out  1  `mem_req & ~mem_done`
- `ram_din`  in  8  RAM read data
- `ram_dout`  out  8  RAM write data
- `ram_a`  out  32  RAM byte address
- `ram_wr`  out  1  RAM write strobe
- `io_buffer_full`  in  1  UART TX buffer full

## Operation
- States: `IDLE`, `RD`, `WR`. A byte counter `cnt` (0..4) and a length `n` are latched at grant.
- `IDLE` grant priority:
  - `mem_req` beats `if_req`, because the MEM instruction is older.
  - A requester whose `done` is high in the current cycle is not granted. This gives one bubble and prevents re-serving a stale held request.
- Grant latches the address, `n`, store data and the requester id.
  - Fetch: `n`=4.
  - Data: `n` = 1/2/4 from `mem_size`; `mem_size`=3 is treated as 4.
- Byte order is little-endian: byte k is at address A+k and maps to bits [8k+7:8k].
- `RD`:
  - Drives `ram_a`=A+k for k=0..n-1 on successive cycles.
  - The RAM returns byte k on `ram_din` one cycle after sampling A+k.
  - The controller captures byte k into the assembly register; unused upper bytes are 0.
  - After capturing byte n-1, it pulses the requester's `done` with the data and goes to `IDLE`.
- `WR`:
  - Drives `ram_wr`=1, `ram_a`=A+k and `ram_dout`=byte k for k=0..n-1.
  - After byte n-1, it pulses `mem_done` and goes to `IDLE`.
  - IF never writes.
- `ram_wr` is 0 in every cycle that is not a `WR` byte cycle.
- `rdy`=0: no register updates and `ram_wr` is forced to 0.
  - `ram_a` holds, so the RAM re-presents the pending byte and the capture stays consistent.
- Addresses wrap modulo 2^32.
- Reset values: all registered outputs are 0, i.e. `ram_a`, `ram_dout`, `ram_wr`, `if_done`, `if_data`, `mem_done`, `mem_rdata`. The state is `IDLE` and `cnt` is 0.
- `if_stall` and `mem_stall` are 0 while `rst` is high.
- Reset mid-operation: the block returns to `IDLE` immediately and no `done` is issued. Bytes already written stay written.

## Timing
- Edges are numbered from E0, the edge at which `IDLE` grants.
- Read of n bytes:
  - `ram_a`=A+k is valid after E_k.
  - Byte k is captured at E_{k+2}.
  - `done` is high in the cycle after E_{n+1`}.
  - Latency from grant edge to `done` cycle: n+1 cycles. A word fetch therefore takes 5 cycles.
- Write of n bytes:
  - Byte k is on the bus after E_k.
  - `done` is high in the cycle after E_n, so latency is n cycles.
- Earliest next grant is E_{n+2} for reads and E_{n+1} for writes; both are one cycle after the `done` cycle.
- Stall outputs are combinational from `req` and registered `done`. They drop in the `done` cycle, so the stage advances at the following edge.

## Configuration
- `MEM_CTRL_IO_WAIT_EN` defined:
  - A store whose address is 0x30000 or 0x30004 (`IO_ADDR` constants) is not granted while `io_buffer_full`=1. It stays pending in `IDLE`.
  - A fetch may be granted ahead of it meanwhile.
  - `io_buffer_full` is sampled only at grant.
- Not defined: `io_buffer_full` is ignored and IO stores are granted like any store.

## Structure
- `consts.vh` holds:
  - `SIZE_B`, `SIZE_H`, `SIZE_W`
  - `IO_ADDR_OUT` (0x30000) and `IO_ADDR_HALT` (0x30004)
  - the `IDLE`, `RD`, `WR` state encoding
  - `RamAddrBus` and `RamDataBus` widths
- No sub-module; the byte lane select and assembly stay inline.

## Test plan
- Fetch: `if_req`, `if_addr`=0x100, RAM holds 13 05 00 00 at 0x100..0x103 -> `ram_a` 0x100..0x103 on successive cycles; `if_done` 5 cycles after grant with `if_data`=0x00000513; `if_stall` high until then.
- Contention: `if_req` and `mem_req` (load word at 0x200) rise together -> MEM served first with `mem_done` and `mem_rdata`; one bubble; then IF granted.
- Store half: `mem_we`=1, `mem_size`=`SIZE_H`, `mem_addr`=0x1FF, `mem_wdata`=0xAABBCCDD -> `ram_wr` for 2 cycles writing DD@0x1FF and CC@0x200; `mem_done` 2 cycles after grant.
- Byte load then `rdy`=0 for 3 cycles mid-word-read -> `ram_wr`=0, state frozen; the final word is correct and the latency is extended by exactly 3 cycles.
- `MEM_CTRL_IO_WAIT_EN`: store byte to 0x30000 with `io_buffer_full`=1 for 4 cycles -> no `ram_wr`; a pending fetch completes meanwhile; the store writes after `io_buffer_full` falls. Separately, `rst` asserted mid-word-write -> `ram_wr`=0 immediately and no `mem_done`.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared widths, access-size codes, IO addresses and FSM encoding for mem_ctrl.
// Also holds the little-endian byte lane helpers.
package mem_ctrl_pkg;

    localparam int unsigned RAM_ADDR_W = 32;
    localparam int unsigned RAM_DATA_W = 8;

    typedef logic [RAM_ADDR_W-1:0] ram_addr_t;
    typedef logic [RAM_DATA_W-1:0] ram_data_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam ram_addr_t IO_ADDR_OUT  = 32'h0003_0000;
    localparam ram_addr_t IO_ADDR_HALT = 32'h0003_0004;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_e;

    // Size code 3 is not architectural; it is served as a full word.
    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic ram_data_t lane_get(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] lane_put(input logic [31:0] word, input logic [1:0] idx,
                                             input ram_data_t b);
        logic [31:0] w;
        w = word;
        w[{idx, 3'b000} +: 8] = b;
        return w;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM port arbiter for instruction fetch and data access (MEM wins).
// Optional MEM_CTRL_IO_WAIT_EN holds IO stores while the UART TX buffer is full.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    output logic        if_stall,
    output logic        mem_stall,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    input  logic        io_buffer_full
);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  n_q, n_d;
    logic        is_if_q, is_if_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] asm_q, asm_d;
    ram_addr_t   ram_a_q, ram_a_d;
    ram_data_t   ram_dout_q, ram_dout_d;
    logic        ram_wr_q, ram_wr_d;
    logic        if_done_q, if_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic        mem_done_q, mem_done_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic        io_hold;
    logic        mem_ok;
    logic        if_ok;
    logic [31:0] captured;

`ifdef MEM_CTRL_IO_WAIT_EN
    assign io_hold = mem_we & io_buffer_full &
                     ((mem_addr == IO_ADDR_OUT) | (mem_addr == IO_ADDR_HALT));
`else
    logic unused_io;
    assign io_hold   = 1'b0;
    assign unused_io = io_buffer_full;
`endif

    // A requester whose done is showing is still holding its old request.
    assign mem_ok = mem_req & ~mem_done_q & ~io_hold;
    assign if_ok  = if_req & ~if_done_q;

    // Byte cnt-1 arrives one cycle after its address was sampled by the RAM.
    assign captured = lane_put(asm_q, 2'(cnt_q - 3'd1), ram_din);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        is_if_d     = is_if_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = 1'b0;
        if_done_d   = 1'b0;
        if_data_d   = if_data_q;
        mem_done_d  = 1'b0;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            IDLE: begin
                if (mem_ok) begin
                    is_if_d = 1'b0;
                    n_d     = size_to_len(mem_size);
                    ram_a_d = mem_addr;
                    wdata_d = mem_wdata;
                    cnt_d   = '0;
                    asm_d   = '0;
                    if (mem_we) begin
                        state_d    = WR;
                        ram_wr_d   = 1'b1;
                        ram_dout_d = mem_wdata[7:0];
                    end else begin
                        state_d = RD;
                    end
                end else if (if_ok) begin
                    is_if_d = 1'b1;
                    n_d     = 3'd4;
                    ram_a_d = if_addr;
                    cnt_d   = '0;
                    asm_d   = '0;
                    state_d = RD;
                end
            end

            RD: begin
                cnt_d = cnt_q + 3'd1;
                if ((cnt_q + 3'd1) < n_q) begin
                    ram_a_d = ram_a_q + 32'd1;
                end
                if (cnt_q != 3'd0) begin
                    asm_d = captured;
                end
                if (cnt_q == n_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (is_if_q) begin
                        if_done_d = 1'b1;
                        if_data_d = captured;
                    end else begin
                        mem_done_d  = 1'b1;
                        mem_rdata_d = captured;
                    end
                end
            end

            WR: begin
                if ((cnt_q + 3'd1) == n_q) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    mem_done_d = 1'b1;
                end else begin
                    cnt_d      = cnt_q + 3'd1;
                    ram_a_d    = ram_a_q + 32'd1;
                    ram_wr_d   = 1'b1;
                    ram_dout_d = lane_get(wdata_q, 2'(cnt_q + 3'd1));
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            is_if_q     <= 1'b0;
            wdata_q     <= '0;
            asm_q       <= '0;
            ram_a_q     <= '0;
            ram_dout_q  <= '0;
            ram_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            if_data_q   <= '0;
            mem_done_q  <= 1'b0;
            mem_rdata_q <= '0;
        end else if (rdy) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            is_if_q     <= is_if_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_done_q   <= if_done_d;
            if_data_q   <= if_data_d;
            mem_done_q  <= mem_done_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign ram_a     = ram_a_q;
    assign ram_dout  = ram_dout_q;
    // A frozen write cycle must not strobe the RAM; the byte is re-issued once rdy returns.
    assign ram_wr    = ram_wr_q & rdy;
    assign if_done   = if_done_q;
    assign if_data   = if_data_q;
    assign mem_done  = mem_done_q;
    assign mem_rdata = mem_rdata_q;
    assign if_stall  = if_req & ~if_done_q & ~rst;
    assign mem_stall = mem_req & ~mem_done_q & ~rst;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: byte-level reference memory plus a behavioural RAM device.
// The IO-wait scenario follows MEM_CTRL_IO_WAIT_EN when the bench is built with it.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        if_stall;
    logic        mem_stall;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        io_buffer_full;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_size       (mem_size),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_done       (mem_done),
        .mem_rdata      (mem_rdata),
        .if_stall       (if_stall),
        .mem_stall      (mem_stall),
        .ram_din        (ram_din),
        .ram_dout       (ram_dout),
        .ram_a          (ram_a),
        .ram_wr         (ram_wr),
        .io_buffer_full (io_buffer_full)
    );

    typedef struct {
        bit          store;
        int          n;
        logic [31:0] data;
        int unsigned issue;
        int          lat;
    } exp_t;

    exp_t        if_q[$];
    exp_t        mem_q[$];
    logic [7:0]  ram[logic [31:0]];
    logic [7:0]  ref_mem[logic [31:0]];
    int          vectors = 0;
    int          miscompares = 0;
    int unsigned cyc = 0;
    int unsigned wr_cnt = 0;

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Synchronous byte RAM; it freezes with the rest of the system while rdy is low.
    initial ram_din = 8'h00;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && rdy) begin
            if (ram_wr) ram[ram_a] = ram_dout;
            ram_din <= ram_rd(ram_a);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ram_wr) wr_cnt++;
            chk("if_stall",  {31'b0, if_stall},  {31'b0, if_req & ~if_done});
            chk("mem_stall", {31'b0, mem_stall}, {31'b0, mem_req & ~mem_done});
            if (!rdy) chk("ram_wr_frozen", {31'b0, ram_wr}, 32'd0);
            if (if_done) begin
                if (if_q.size() == 0) begin
                    chk("unexpected_if_done", 32'd1, 32'd0);
                end else begin
                    e = if_q.pop_front();
                    chk("if_data", if_data, e.data);
                    if (e.lat >= 0) chk("if_latency", cyc - e.issue, 32'(e.lat));
                end
            end
            if (mem_done) begin
                if (mem_q.size() == 0) begin
                    chk("unexpected_mem_done", 32'd1, 32'd0);
                end else begin
                    e = mem_q.pop_front();
                    if (e.store) chk("store_wr_cycles", wr_cnt, 32'(e.n));
                    else         chk("mem_rdata", mem_rdata, e.data);
                    if (e.lat >= 0) chk("mem_latency", cyc - e.issue, 32'(e.lat));
                end
                wr_cnt = 0;
            end
        end
    end

    function automatic int len_of(input bit is_if, input logic [1:0] size);
        if (is_if) return 4;
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic exp_t make_exp(input bit is_if, input bit we, input logic [1:0] size,
                                      input logic [31:0] addr, input logic [31:0] wdata,
                                      input int extra);
        exp_t e;
        e.n     = len_of(is_if, size);
        e.store = !is_if && we;
        e.data  = '0;
        for (int k = 0; k < e.n; k++) begin
            if (e.store) ref_mem[addr + 32'(k)] = wdata[8*k +: 8];
            else         e.data[8*k +: 8] = ref_rd(addr + 32'(k));
        end
        e.issue = cyc;
        e.lat   = (e.store ? e.n + 1 : e.n + 2) + extra;
        return e;
    endfunction

    // Issues one request at #1 after an edge; it is granted at the next edge.
    task automatic do_req(input bit is_if, input bit we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int stall_off, input int stall_len);
        exp_t e;
        bit   seen;
        e = make_exp(is_if, we, size, addr, wdata, stall_len);
        if (is_if) begin
            if_q.push_back(e);
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            mem_q.push_back(e);
            mem_req   = 1'b1;
            mem_we    = we;
            mem_size  = size;
            mem_addr  = addr;
            mem_wdata = wdata;
        end
        rdy  = !(stall_len > 0 && stall_off == 0);
        seen = 1'b0;
        for (int ed = 1; ed <= 60 && !seen; ed++) begin
            @(posedge clk);
            #1;
            rdy = !(stall_len > 0 && ed >= stall_off && ed < stall_off + stall_len);
            if (stall_len == 0 && ed - 1 < e.n) begin
                chk("ram_a", ram_a, addr + 32'(ed - 1));
                if (e.store) begin
                    chk("ram_dout", {24'b0, ram_dout}, {24'b0, wdata[8*(ed-1) +: 8]});
                    chk("ram_wr", {31'b0, ram_wr}, 32'd1);
                end
            end
            seen = is_if ? if_done : mem_done;
        end
        if (!seen) begin
            chk("done_timeout", 32'd0, 32'd1);
            if_q.delete();
            mem_q.delete();
        end
        rdy = 1'b1;
        @(posedge clk);
        #1;
        if_req  = 1'b0;
        mem_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        bit   md, id;
        rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0;
        if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2;
        if_addr = '0; mem_addr = '0; mem_wdata = '0;

        ref_mem[32'h100] = 8'h13; ref_mem[32'h101] = 8'h05;
        ref_mem[32'h102] = 8'h00; ref_mem[32'h103] = 8'h00;
        for (int i = 0; i < 64; i++) ref_mem[32'h1000 + 32'(i)] = 8'($urandom);
        for (int i = 0; i < 40; i++) ref_mem[32'h2000 + 32'(i)] = 8'($urandom);
        for (int i = 0; i < 4; i++)  ref_mem[32'h200 + 32'(i)]  = 8'($urandom);
        foreach (ref_mem[a]) ram[a] = ref_mem[a];

        #1;
        chk("rst_if_stall",  {31'b0, if_stall},  32'd0);
        chk("rst_mem_stall", {31'b0, mem_stall}, 32'd0);
        if_req = 1'b0; mem_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ram_a", ram_a, 32'd0);
        chk("rst_ram_dout", {24'b0, ram_dout}, 32'd0);
        chk("rst_ram_wr", {31'b0, ram_wr}, 32'd0);
        chk("rst_if_done", {31'b0, if_done}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_mem_done", {31'b0, mem_done}, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed: fetch of 0x00000513, then a MEM/IF collision.
        do_req(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 0, 0);
        chk("fetch_word", if_data, 32'h0000_0513);

        e = make_exp(1'b0, 1'b0, 2'd2, 32'h200, 32'h0, 0);
        mem_q.push_back(e);
        e = make_exp(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 0);
        e.lat = 12;
        if_q.push_back(e);
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h200;
        if_req = 1'b1; if_addr = 32'h100;
        md = 1'b0; id = 1'b0;
        for (int ed = 1; ed <= 40 && !(md && id); ed++) begin
            @(posedge clk);
            #1;
            if (md) mem_req = 1'b0;
            if (id) if_req = 1'b0;
            if (mem_done) md = 1'b1;
            if (if_done) id = 1'b1;
        end
        if (!(md && id)) chk("contention_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        mem_req = 1'b0; if_req = 1'b0;

        // Directed: half store straddling 0x200, byte load, stalled word load.
        do_req(1'b0, 1'b1, 2'd1, 32'h1FF, 32'hAABB_CCDD, 0, 0);
        do_req(1'b0, 1'b0, 2'd0, 32'h200, 32'h0, 0, 0);
        do_req(1'b0, 1'b0, 2'd2, 32'h1FE, 32'h0, 2, 3);
        do_req(1'b0, 1'b0, 2'd3, 32'h1000, 32'h0, 0, 0);
        do_req(1'b0, 1'b1, 2'd2, 32'hFFFF_FFFE, 32'h8765_4321, 0, 0);
        do_req(1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF, 32'h0, 0, 0);

        // Reset in the middle of a word store: byte 0 is already in RAM, nothing else.
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2;
        mem_addr = 32'h300; mem_wdata = 32'h1122_3344;
        ref_mem[32'h300] = 8'h44;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_ram_wr", {31'b0, ram_wr}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_ram_wr", {31'b0, ram_wr}, 32'd0);
        chk("midrst_mem_stall", {31'b0, mem_stall}, 32'd0);
        mem_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr_cnt = 0;
        repeat (4) @(posedge clk);
        #1;
        do_req(1'b0, 1'b0, 2'd2, 32'h300, 32'h0, 0, 0);

`ifdef MEM_CTRL_IO_WAIT_EN
        io_buffer_full = 1'b1;
        e = make_exp(1'b0, 1'b1, 2'd0, 32'h3_0000, 32'h5A, 0);
        e.lat = -1;
        mem_q.push_back(e);
        e = make_exp(1'b1, 1'b0, 2'd2, 32'h1000, 32'h0, 0);
        if_q.push_back(e);
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd0;
        mem_addr = 32'h3_0000; mem_wdata = 32'h5A;
        if_req = 1'b1; if_addr = 32'h1000;
        id = 1'b0;
        for (int ed = 1; ed <= 40 && !id; ed++) begin
            @(posedge clk);
            #1;
            chk("io_blocked_wr", {31'b0, ram_wr}, 32'd0);
            if (if_done) id = 1'b1;
        end
        if (!id) chk("io_fetch_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        chk("io_blocked_wr2", {31'b0, ram_wr}, 32'd0);
        io_buffer_full = 1'b0;
        md = 1'b0;
        for (int ed = 1; ed <= 20 && !md; ed++) begin
            @(posedge clk);
            #1;
            if (mem_done) md = 1'b1;
        end
        if (!md) chk("io_store_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        mem_req = 1'b0;
`else
        io_buffer_full = 1'b1;
        do_req(1'b0, 1'b1, 2'd0, 32'h3_0000, 32'h5A, 0, 0);
        io_buffer_full = 1'b0;
`endif

        for (int t = 0; t < 60; t++) begin
            int unsigned kind, off, len, n;
            logic [1:0]  sz;
            logic [31:0] ad;
            kind = $urandom_range(0, 2);
            sz   = 2'($urandom_range(0, 3));
            ad   = (kind == 0) ? 32'h1000 + $urandom_range(0, 60)
                               : 32'h2000 + $urandom_range(0, 36);
            if ($urandom_range(0, 9) == 0) ad = 32'hFFFF_FFFC + $urandom_range(0, 3);
            n   = 32'(len_of(kind == 0, sz));
            off = 0;
            len = 0;
            if ($urandom_range(0, 3) == 0) begin
                off = $urandom_range(0, n);
                len = $urandom_range(1, 3);
            end
            do_req(kind == 0, kind == 2, sz, ad, $urandom, int'(off), int'(len));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("if_queue_empty", 32'(if_q.size()), 32'd0);
        chk("mem_queue_empty", 32'(mem_q.size()), 32'd0);
        foreach (ref_mem[a]) chk("ram_content", {24'b0, ram_rd(a)}, {24'b0, ref_mem[a]});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
